// File: rtl/rf_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : rf_arb_pkg
// Purpose  : Shared constants and helper functions for the register-file
//            write arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rf_arb_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  // Ceiling log2; callers clamp the result to at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [RF_NREG-1:0] decode5to32(input logic [RF_AW-1:0] a);
    logic [RF_NREG-1:0] d;
    d    = '0;
    d[a] = 1'b1;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_arb_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rf_arb_rr_pick
// Purpose  : Combinational round-robin picker. Scans from ptr upward with
//            wrap modulo NREQ and returns a one-hot grant plus the winner index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_arb_rr_pick
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            freeze,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            any
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [PW:0] c_nreq = (PW+1)'(NREQ);

  logic [PW:0] w_pos;

  always_comb begin
    gnt    = '0;
    winner = '0;
    any    = 1'b0;
    w_pos  = '0;
    if (!freeze) begin
      for (int k = 0; k < NREQ; k++) begin
        w_pos = {1'b0, ptr} + (PW+1)'(k);
        if (w_pos >= c_nreq) begin
          w_pos = w_pos - c_nreq;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (!any && (w_pos == (PW+1)'(i)) && req[i]) begin
            any    = 1'b1;
            gnt[i] = 1'b1;
            winner = PW'(i);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rf_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port.
//            Registers the winner and drives a one-hot LOAD vector.
//            Option macro: RF_ARB_R0_GUARD_EN (suppress LOAD for register 0).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*RF_AW-1:0] addr,
  input  logic [NREQ*RF_DW-1:0] data,
  input  logic                  freeze,
  output logic [NREQ-1:0]       gnt,
  output logic [RF_NREG-1:0]    load,
  output logic [RF_AW-1:0]      waddr,
  output logic [RF_DW-1:0]      wdata,
  output logic                  wvalid
);

  localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam logic [PW-1:0] c_last = PW'(NREQ - 1);

  logic [PW-1:0]      r_ptr;
  logic [NREQ-1:0]    w_gnt_raw;
  logic [PW-1:0]      w_win;
  logic               w_any;
  logic               w_accept;
  logic [RF_AW-1:0]   w_win_addr;
  logic [RF_DW-1:0]   w_win_data;
  logic [RF_NREG-1:0] w_load_next;
  logic [PW-1:0]      w_ptr_next;

  rf_arb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .freeze (freeze),
    .gnt    (w_gnt_raw),
    .winner (w_win),
    .any    (w_any)
  );

  // Grants are masked combinationally while reset is asserted.
  assign gnt      = reset ? '0 : w_gnt_raw;
  assign w_accept = w_any & ~reset;

  always_comb begin
    w_win_addr = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_raw[i]) begin
        w_win_addr = addr[i*RF_AW +: RF_AW];
        w_win_data = data[i*RF_DW +: RF_DW];
      end
    end
  end

`ifdef RF_ARB_R0_GUARD_EN
  assign w_load_next = (w_win_addr == '0) ? '0 : decode5to32(w_win_addr);
`else
  assign w_load_next = decode5to32(w_win_addr);
`endif

  assign w_ptr_next = (w_win == c_last) ? '0 : (w_win + PW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      load   <= '0;
      waddr  <= '0;
      wdata  <= '0;
      wvalid <= 1'b0;
    end else if (w_accept) begin
      r_ptr  <= w_ptr_next;
      load   <= w_load_next;
      waddr  <= w_win_addr;
      wdata  <= w_win_data;
      wvalid <= 1'b1;
    end else begin
      load   <= '0;
      wvalid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_rf_write_arbiter
// Purpose  : Self-checking bench for rf_write_arbiter (NREQ=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [14:0] addr;
  logic [95:0] data;
  logic        freeze;
  logic [2:0]  gnt;
  logic [31:0] load;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wvalid;

  typedef struct {
    logic [31:0] load;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_ptr   = 0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  rf_write_arbiter #(.NREQ(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .addr   (addr),
    .data   (data),
    .freeze (freeze),
    .gnt    (gnt),
    .load   (load),
    .waddr  (waddr),
    .wdata  (wdata),
    .wvalid (wvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_load(input logic [4:0] a);
`ifdef RF_ARB_R0_GUARD_EN
    if (a == 5'd0) return 32'h0;
`endif
    return 32'h1 << a;
  endfunction

  // Reference model: computes the expected grant, queues the expected write.
  task automatic predict(output logic [2:0] eg);
    int   w;
    exp_t e;
    eg = 3'b000;
    w  = -1;
    if (!reset && !freeze) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (w < 0 && req[idx]) w = idx;
      end
    end
    if (w >= 0) begin
      eg      = 3'b001 << w;
      e.waddr = addr[w*5 +: 5];
      e.wdata = data[w*32 +: 32];
      e.load  = exp_load(e.waddr);
      sbq.push_back(e);
      m_ptr = (w + 1) % 3;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 3'b111; freeze = 1'b0;
    addr = {5'd3, 5'd2, 5'd1}; data = {32'h3, 32'h2, 32'h1};
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (gnt !== 3'b000 || load !== 32'h0 || wvalid !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold: gnt=%b load=%h wvalid=%b waddr=%0d wdata=%h, want all zero",
                 gnt, load, wvalid, waddr, wdata);
      end
    end
    reset = 1'b0; req = 3'b000;
    for (int c = 0; c < 2; c++) begin
      logic [2:0] eg;
      #3; predict(eg);
      n_tests++;
      if (gnt !== eg) begin
        n_fail++; $display("FAIL reset_idle_gnt: got %b want %b", gnt, eg);
      end
      @(posedge clk); #1;
      n_tests++;
      if (wvalid !== 1'b0 || load !== 32'h0 || waddr !== 5'd0 || wdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_idle_out: load=%h wvalid=%b waddr=%0d wdata=%h, want all zero",
                 load, wvalid, waddr, wdata);
      end
    end
  endtask

  task automatic test_round_robin();
    addr = {5'd21, 5'd12, 5'd3};
    data = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    req  = 3'b111; freeze = 1'b0;
    for (int c = 0; c < 7; c++) begin
      logic [2:0] eg;
      logic [2:0] want;
      exp_t       e;
      if (c == 6) req = 3'b000;
      want = (c < 6) ? (3'b001 << (c % 3)) : 3'b000;
      #3; predict(eg);
      n_tests++;
      if (gnt !== want || gnt !== eg) begin
        n_fail++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt, want);
      end
      @(posedge clk); #1;
      n_tests++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (wvalid !== 1'b1 || load !== e.load || waddr !== e.waddr || wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL rr_out c=%0d: v=%b load=%h a=%0d d=%h want v=1 load=%h a=%0d d=%h",
                   c, wvalid, load, waddr, wdata, e.load, e.waddr, e.wdata);
        end
        m_waddr = e.waddr; m_wdata = e.wdata;
      end else if (wvalid !== 1'b0 || load !== 32'h0 || waddr !== m_waddr || wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL rr_idle c=%0d: v=%b load=%h a=%0d d=%h want v=0 load=0 a=%0d d=%h",
                 c, wvalid, load, waddr, wdata, m_waddr, m_wdata);
      end
    end
  endtask

  task automatic test_single_write();
    addr = {5'd0, 5'd7, 5'd0};
    data = {32'h0, 32'hDEAD_BEEF, 32'h0};
    freeze = 1'b0;
    for (int c = 0; c < 2; c++) begin
      logic [2:0] eg;
      exp_t       e;
      req = (c == 0) ? 3'b010 : 3'b000;
      #3; predict(eg);
      n_tests++;
      if (gnt !== eg || (c == 0 && gnt !== 3'b010)) begin
        n_fail++; $display("FAIL single_gnt c=%0d: got %b want %b", c, gnt, eg);
      end
      @(posedge clk); #1;
      n_tests++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (wvalid !== 1'b1 || load !== 32'h0000_0080 || load !== e.load || waddr !== e.waddr || wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL single_out: v=%b load=%h a=%0d d=%h want v=1 load=00000080 a=7 d=deadbeef",
                   wvalid, load, waddr, wdata);
        end
        m_waddr = e.waddr; m_wdata = e.wdata;
      end else if (wvalid !== 1'b0 || load !== 32'h0 || waddr !== m_waddr || wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL single_hold: v=%b load=%h a=%0d d=%h want v=0 load=0 a=%0d d=%h",
                 wvalid, load, waddr, wdata, m_waddr, m_wdata);
      end
    end
  endtask

  task automatic test_freeze();
    addr = {5'd0, 5'd0, 5'd15};
    data = {32'h0, 32'h0, 32'hF00D_0015};
    for (int c = 0; c < 5; c++) begin
      logic [2:0] eg;
      exp_t       e;
      freeze = (c < 3);
      req    = (c < 4) ? 3'b001 : 3'b000;
      #3; predict(eg);
      n_tests++;
      if (gnt !== eg) begin
        n_fail++; $display("FAIL freeze_gnt c=%0d: got %b want %b", c, gnt, eg);
      end
      @(posedge clk); #1;
      n_tests++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (wvalid !== 1'b1 || load !== e.load || waddr !== e.waddr || wdata !== e.wdata) begin
          n_fail++;
          $display("FAIL freeze_out c=%0d: v=%b load=%h a=%0d d=%h want v=1 load=%h a=%0d d=%h",
                   c, wvalid, load, waddr, wdata, e.load, e.waddr, e.wdata);
        end
        m_waddr = e.waddr; m_wdata = e.wdata;
      end else if (wvalid !== 1'b0 || load !== 32'h0 || waddr !== m_waddr || wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL freeze_idle c=%0d: v=%b load=%h a=%0d d=%h want v=0 load=0 a=%0d d=%h",
                 c, wvalid, load, waddr, wdata, m_waddr, m_wdata);
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_r0_guard();
    addr = {5'd0, 5'd0, 5'd0};
    data = {32'h0, 32'h0, 32'h0000_1234};
    freeze = 1'b0;
    for (int c = 0; c < 2; c++) begin
      logic [2:0] eg;
      exp_t       e;
      req = (c == 0) ? 3'b001 : 3'b000;
      #3; predict(eg);
      n_tests++;
      if (gnt !== eg) begin
        n_fail++; $display("FAIL r0_gnt c=%0d: got %b want %b", c, gnt, eg);
      end
      @(posedge clk); #1;
      n_tests++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (wvalid !== 1'b1 || load !== e.load || waddr !== 5'd0 || wdata !== 32'h0000_1234) begin
          n_fail++;
          $display("FAIL r0_out: v=%b load=%h a=%0d d=%h want v=1 load=%h a=0 d=00001234",
                   wvalid, load, waddr, wdata, e.load);
        end
        m_waddr = e.waddr; m_wdata = e.wdata;
      end else if (wvalid !== 1'b0 || load !== 32'h0 || waddr !== m_waddr || wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL r0_idle: v=%b load=%h a=%0d d=%h want v=0 load=0 a=%0d d=%h",
                 wvalid, load, waddr, wdata, m_waddr, m_wdata);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2:0] eg;
    exp_t       e;
    addr = {5'd30, 5'd0, 5'd9};
    data = {32'hAAAA_0002, 32'h0, 32'hAAAA_0000};
    freeze = 1'b0; req = 3'b001;
    #3; predict(eg);
    n_tests++;
    if (gnt !== eg) begin
      n_fail++; $display("FAIL midrst_pre_gnt: got %b want %b", gnt, eg);
    end
    @(posedge clk); #1;
    req = 3'b000;
    n_tests++;
    e = sbq.pop_front();
    if (wvalid !== 1'b1 || load !== e.load || waddr !== e.waddr || wdata !== e.wdata) begin
      n_fail++;
      $display("FAIL midrst_pre_out: v=%b load=%h a=%0d d=%h want v=1 load=%h a=%0d d=%h",
               wvalid, load, waddr, wdata, e.load, e.waddr, e.wdata);
    end
    #1 reset = 1'b1;
    #1;
    m_ptr = 0; m_waddr = '0; m_wdata = '0; sbq.delete();
    n_tests++;
    if (wvalid !== 1'b0 || load !== 32'h0 || waddr !== 5'd0 || wdata !== 32'h0 || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_async: v=%b load=%h a=%0d d=%h gnt=%b want all zero",
               wvalid, load, waddr, wdata, gnt);
    end
    @(posedge clk); #1;
    reset = 1'b0; req = 3'b101;
    #3; predict(eg);
    n_tests++;
    if (gnt !== 3'b001 || gnt !== eg) begin
      n_fail++; $display("FAIL midrst_first_gnt: got %b want 001", gnt);
    end
    @(posedge clk); #1;
    req = 3'b000;
    n_tests++;
    e = sbq.pop_front();
    if (wvalid !== 1'b1 || load !== e.load || waddr !== e.waddr || wdata !== e.wdata) begin
      n_fail++;
      $display("FAIL midrst_post_out: v=%b load=%h a=%0d d=%h want v=1 load=%h a=%0d d=%h",
               wvalid, load, waddr, wdata, e.load, e.waddr, e.wdata);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_freeze();
    test_r0_guard();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
